// File: rtl/rx_string.sv
// rx_string: stores UART receiver bytes into byte-wide memory as a null-terminated string.
// Optional backspace editing: define RX_BACKSPACE_EN.
module rx_string #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         MAX_LEN    = 32,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_string_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            wr_data,
  output logic                  wr_en,
  output logic                  rx_string_done,
  output logic [ADDR_WIDTH-1:0] rx_string_len,
  output logic                  rx_overflow,
  output logic [3:0]            state_dbg
);

  // Handshake: rx_string_ready and rx_done are levels; only a rising edge
  // (level high now, low on the previous clock) is acted upon. rx_data is
  // taken on the same clock that sees the rx_done rise. There is no back-pressure.

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_WRITE = 4'b0100,
    S_TERM  = 4'b1000
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LEN_LIMIT = ADDR_WIDTH'(MAX_LEN - 1);

  state_t                state, state_nx;
  logic                  ready_q, done_q;
  logic                  start_edge, byte_edge;
  logic [ADDR_WIDTH-1:0] addr_nx, len_nx;
  logic [7:0]            data_nx;
  logic                  wr_en_nx, done_nx, ovf_nx;

  assign start_edge = rx_string_ready & ~ready_q;
  assign byte_edge  = rx_done & ~done_q;
  assign state_dbg  = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      ready_q        <= 1'b0;
      done_q         <= 1'b0;
      addr           <= '0;
      wr_data        <= 8'h00;
      wr_en          <= 1'b0;
      rx_string_done <= 1'b0;
      rx_string_len  <= '0;
      rx_overflow    <= 1'b0;
    end else begin
      state          <= state_nx;
      ready_q        <= rx_string_ready;
      done_q         <= rx_done;
      addr           <= addr_nx;
      wr_data        <= data_nx;
      wr_en          <= wr_en_nx;
      rx_string_done <= done_nx;
      rx_string_len  <= len_nx;
      rx_overflow    <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    data_nx  = wr_data;
    wr_en_nx = 1'b0;
    done_nx  = 1'b0;
    len_nx   = rx_string_len;
    ovf_nx   = rx_overflow;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          addr_nx  = start_addr;
          len_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // The terminator strobe is issued on entry to TERM so that it meets
        // the same one-cycle latency as a data byte.
        if (byte_edge) begin
          if (rx_data == TERM_CHAR || rx_data == 8'h00) begin
            data_nx  = 8'h00;
            wr_en_nx = 1'b1;
            state_nx = S_TERM;
          end
`ifdef RX_BACKSPACE_EN
          else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
            if (rx_string_len != '0) begin
              addr_nx = addr - ADDR_ONE;
              len_nx  = rx_string_len - ADDR_ONE;
            end
          end
`endif
          else if (rx_string_len == LEN_LIMIT) begin
            ovf_nx   = 1'b1;
            data_nx  = 8'h00;
            wr_en_nx = 1'b1;
            state_nx = S_TERM;
          end else begin
            data_nx  = rx_data;
            wr_en_nx = 1'b1;
            state_nx = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_nx  = addr + ADDR_ONE;
        len_nx   = rx_string_len + ADDR_ONE;
        state_nx = S_WAIT;
      end
      S_TERM: begin
        done_nx  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_string.sv
// Directed bench for rx_string: a full-size instance and a MAX_LEN=4 instance share stimulus.
module tb_rx_string;

  logic       clock;
  logic       reset;
  logic       rx_string_ready;
  logic [7:0] start_addr;
  logic [7:0] rx_data;
  logic       rx_done;

  logic [7:0] addr, wr_data, len;
  logic       wr_en, done, ovf;
  logic [3:0] st;
  logic [7:0] addr_s, wr_data_s, len_s;
  logic       wr_en_s, done_s, ovf_s;
  logic [3:0] st_s;

  localparam logic [3:0] ST_IDLE = 4'b0001;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_cnt = 0;
  logic       mon_sel  = 1'b0;
  logic [15:0] exp_q[$];

  rx_string dut (
    .clock(clock), .reset(reset), .rx_string_ready(rx_string_ready),
    .start_addr(start_addr), .rx_data(rx_data), .rx_done(rx_done),
    .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .rx_string_done(done),
    .rx_string_len(len), .rx_overflow(ovf), .state_dbg(st)
  );

  rx_string #(.MAX_LEN(4)) dut_s (
    .clock(clock), .reset(reset), .rx_string_ready(rx_string_ready),
    .start_addr(start_addr), .rx_data(rx_data), .rx_done(rx_done),
    .addr(addr_s), .wr_data(wr_data_s), .wr_en(wr_en_s), .rx_string_done(done_s),
    .rx_string_len(len_s), .rx_overflow(ovf_s), .state_dbg(st_s)
  );

  // clock/reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: every write strobe of the selected instance must match the queue head
  always @(negedge clock) begin
    logic        sel_wr;
    logic        sel_done;
    logic [15:0] got;
    logic [15:0] exp;
    sel_wr   = mon_sel ? wr_en_s : wr_en;
    sel_done = mon_sel ? done_s : done;
    got      = mon_sel ? {addr_s, wr_data_s} : {addr, wr_data};
    if (sel_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, got}, 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("write_addr_data", {16'h0, got}, {16'h0, exp});
      end
    end
    if (sel_done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start(input logic [7:0] a);
    start_addr      = a;
    rx_string_ready = 1'b1;
    tick(1);
    rx_string_ready = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(2);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic end_of_string(input string tag, input int exp_done);
    tick(2);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cycles"}, 32'(done_cnt), 32'(exp_done));
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    reset           = 1'b0;
    rx_string_ready = 1'b0;
    start_addr      = 8'h00;
    rx_data         = 8'h00;
    rx_done         = 1'b0;
    tick(3);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_len", 32'(len), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_state", 32'(st), 32'(ST_IDLE));
    reset = 1'b1;
    tick(2);

    // 1: "AB\r" at 0x10
    mon_sel = 1'b0;
    expect_wr(8'h10, 8'h41); expect_wr(8'h11, 8'h42); expect_wr(8'h12, 8'h00);
    start(8'h10);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
    end_of_string("t1", 1);
    check("t1_len", 32'(len), 32'd2);
    check("t1_ovf", 32'(ovf), 32'd0);
    check("t1_state", 32'(st), 32'(ST_IDLE));
    check("t1_done_low", 32'(done), 32'd0);

    // 2: overflow on the MAX_LEN=4 instance
    mon_sel = 1'b1;
    expect_wr(8'h00, 8'h41); expect_wr(8'h01, 8'h42);
    expect_wr(8'h02, 8'h43); expect_wr(8'h03, 8'h00);
    start(8'h00);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h44); send_byte(8'h45); send_byte(8'h0D);
    end_of_string("t2", 1);
    check("t2_len", 32'(len_s), 32'd3);
    check("t2_ovf", 32'(ovf_s), 32'd1);
    check("t2_state", 32'(st_s), 32'(ST_IDLE));
    check("t2_big_len", 32'(len), 32'd5);
    check("t2_big_ovf", 32'(ovf), 32'd0);
    mon_sel = 1'b0;

    // 3: address wrap, with a start pulse mid-string that must be ignored
    expect_wr(8'hFE, 8'h58); expect_wr(8'hFF, 8'h59);
    expect_wr(8'h00, 8'h5A); expect_wr(8'h01, 8'h00);
    start(8'hFE);
    send_byte(8'h58);
    start(8'h80);
    send_byte(8'h59); send_byte(8'h5A); send_byte(8'h0D);
    end_of_string("t3", 1);
    check("t3_len", 32'(len), 32'd3);
    check("t3_addr", 32'(addr), 32'h01);

    // 4: start and byte edges together (byte dropped), then immediate terminator
    start_addr      = 8'h40;
    rx_data         = 8'h5A;
    rx_string_ready = 1'b1;
    rx_done         = 1'b1;
    tick(1);
    rx_string_ready = 1'b0;
    rx_done         = 1'b0;
    tick(2);
    check("t4_len_held_cleared", 32'(len), 32'd0);
    expect_wr(8'h40, 8'h00);
    send_byte(8'h0D);
    end_of_string("t4", 1);
    check("t4_len", 32'(len), 32'd0);

    // 5: reset asserted while the 'B' strobe is high
    expect_wr(8'h10, 8'h41); expect_wr(8'h11, 8'h42);
    start(8'h10);
    send_byte(8'h41);
    rx_data = 8'h42;
    rx_done = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    check("t5_wr_en_async", 32'(wr_en), 32'd0);
    check("t5_state_async", 32'(st), 32'(ST_IDLE));
    check("t5_addr_async", 32'(addr), 32'h0);
    rx_done = 1'b0;
    end_of_string("t5", 0);
    reset = 1'b1;
    tick(1);
    expect_wr(8'h10, 8'h41); expect_wr(8'h11, 8'h42); expect_wr(8'h12, 8'h00);
    start(8'h10);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
    end_of_string("t5b", 1);
    check("t5b_len", 32'(len), 32'd2);

    // 6: backspace byte
`ifdef RX_BACKSPACE_EN
    expect_wr(8'h00, 8'h41); expect_wr(8'h01, 8'h42);
    expect_wr(8'h01, 8'h43); expect_wr(8'h02, 8'h00);
`else
    expect_wr(8'h00, 8'h41); expect_wr(8'h01, 8'h42); expect_wr(8'h02, 8'h08);
    expect_wr(8'h03, 8'h43); expect_wr(8'h04, 8'h00);
`endif
    start(8'h00);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h08);
    send_byte(8'h43); send_byte(8'h0D);
    end_of_string("t6", 1);
`ifdef RX_BACKSPACE_EN
    check("t6_len", 32'(len), 32'd2);
`else
    check("t6_len", 32'(len), 32'd4);
`endif

    // 7: 0x00 byte also terminates
    expect_wr(8'h20, 8'h51); expect_wr(8'h21, 8'h00);
    start(8'h20);
    send_byte(8'h51); send_byte(8'h00);
    end_of_string("t7", 1);
    check("t7_len", 32'(len), 32'd1);
    check("t7_ovf", 32'(ovf), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
